free_release_queue: RTL
=======================

Name: free_release_queue

Overview:
- Commit-side producer for the physical-register free list: drives the free list's free port (free_en/free_phys).
- Accepts up to two retiring instructions per cycle from the ROB commit stage, each carrying the superseded (old) physical destination register.
- Buffers the old registers in a FIFO and releases one per cycle to the free list, which consumes at most one free per cycle.
- Sits between the ROB retire logic and the free list; never frees the physical register bound to XZR.

Parameters:
- PHYS_REGS, core_pkg::PREGS, number of physical registers; physical tag width is fixed at 6 bits.
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- ZERO_PREG, 31, physical tag permanently mapped to XZR; never released.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- commit_valid  in  2  per-slot retire strobe; slot 0 is older than slot 1.
- commit_has_dest  in  2  per-slot: instruction wrote a register, so old_phys is meaningful.
- commit_old_phys  in  2x6  per-slot superseded physical tag.
- commit_ready  out  1  high when at least 2 free FIFO entries remain; combinational from count.
- free_en  out  1  registered release strobe to the free list.
- free_phys  out  6  registered tag being released; valid only when free_en=1.
- occupancy  out  $clog2(DEPTH)+1  current FIFO count.
- drop_err  out  1  sticky; set when a commit arrives while commit_ready=0, or (feature) on a duplicate free.

Behaviour:
- Reset (synchronous, active-high, clk domain): head, tail and count clear to 0; free_en=0; free_phys=0; drop_err=0; commit_ready=1. Reset mid-operation discards all pending entries; no free is issued in the reset cycle or the following cycle.
- Slot qualification: a slot enqueues iff commit_valid[i] & commit_has_dest[i] & (commit_old_phys[i] != ZERO_PREG) & (commit_old_phys[i] < PHYS_REGS). Out-of-range tags are silently discarded.
- Ordering: slot 0 is written before slot 1. Zero, one or two writes per cycle; tail advances by the number written, modulo DEPTH.
- Release path:
  - Each cycle, if count>0 (using pre-update count), pop the head; the next cycle free_en=1 and free_phys=the popped tag.
  - Otherwise free_en=0 next cycle.
  - Throughput: one release per cycle, not stalled by anything.
- Latency: a tag enqueued in cycle N into an empty FIFO appears on free_en/free_phys in cycle N+2 (write at N edge, pop at N+1 edge, visible after it). There is no same-cycle bypass.
- Count update: count_next = count + writes − pop. Simultaneous push and pop is legal at any occupancy, including full−1 and 1.
- Backpressure: commit_ready = (DEPTH − count) >= 2.
  - ROB must not retire when commit_ready=0.
  - If it does anyway, the qualifying slots are dropped (no write) and drop_err sets.
  - Pop still proceeds in that cycle.
- Full: count never exceeds DEPTH.
- Empty: free_en held low; free_phys holds its last value.
- Wrap-around: head and tail are log2(DEPTH) bits and wrap naturally; count distinguishes full from empty.
- No flush input: committed frees are architectural and survive pipeline flush.

Optional Feature:
- Macro: FREE_DUP_CHECK_EN.
- With the macro defined:
  - Keep a PHYS_REGS-bit pending mask: set on enqueue, cleared on pop.
  - A qualifying slot whose tag is already pending, or equal to the other slot's tag in the same cycle (slot 1 loses), is not enqueued and sets drop_err.
  - Mask clears on reset.
- Without the macro: no mask is built; duplicates are enqueued and released twice.

Decomposition:
- core_pkg provides PREGS, the phys_tag_t typedef (logic [5:0]) and the COMMIT_WIDTH=2 constant.
- One sub-module is natural: frq_fifo, a 2-write/1-read circular buffer parameterised by DEPTH and element type.
- The top level holds slot qualification, the optional duplicate mask, drop_err and the output register.

Test Plan:
- Reset, then a single slot-0 commit with old_phys=7 in cycle 0 -> free_en=1, free_phys=7 in cycle 2; free_en=0 in every other cycle.
- Dual commit each cycle with tags 10/11, 12/13, … for 8 cycles -> frees emerge one per cycle in exact order 10..25; commit_ready falls when occupancy reaches 15 (DEPTH=16); occupancy never exceeds 16.
- Commits with old_phys=31 (ZERO_PREG), has_dest=0, and old_phys=63 with PHYS_REGS=48 -> nothing enqueued, occupancy stays 0, no free_en.
- Fill to 15, then commit 2 while commit_ready=0 -> drop_err=1, occupancy becomes 14 (pop only), no corrupted entries on drain.
- Push 20 entries across wrap with concurrent pops, assert reset mid-drain -> free_en=0 the cycle after reset, occupancy=0, next commit of 3 releases 3 two cycles later.
- With FREE_DUP_CHECK_EN: same-cycle slots both 9 -> one free of 9, drop_err=1; without the macro -> two frees of 9.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core-wide constants and types.
//   PREGS        - number of physical registers
//   COMMIT_WIDTH - instructions retired per cycle
//   phys_tag_t   - physical register tag (fixed 6 bits)
package core_pkg;
    localparam int PREGS        = 48;
    localparam int COMMIT_WIDTH = 2;
    localparam int TAG_W        = 6;

    typedef logic [TAG_W-1:0] phys_tag_t;
endpackage

// File: rtl/free_release_queue_if.sv
// free_release_queue_if: commit-side bundle between ROB retire logic and the
// free-release queue, plus the release port towards the free list.
//   master : retire side (drives commit_*; observes ready/free/status)
//   slave  : the queue itself
interface free_release_queue_if #(
    parameter int DEPTH = 16
);
    import core_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [COMMIT_WIDTH-1:0] commit_valid;
    logic [COMMIT_WIDTH-1:0] commit_has_dest;
    phys_tag_t [COMMIT_WIDTH-1:0] commit_old_phys;
    logic                    commit_ready;
    logic                    free_en;
    phys_tag_t               free_phys;
    logic [CW-1:0]           occupancy;
    logic                    drop_err;

    modport master (
        output commit_valid, commit_has_dest, commit_old_phys,
        input  commit_ready, free_en, free_phys, occupancy, drop_err
    );

    modport slave (
        input  commit_valid, commit_has_dest, commit_old_phys,
        output commit_ready, free_en, free_phys, occupancy, drop_err
    );
endinterface

// File: rtl/frq_fifo.sv
// frq_fifo: circular buffer with two write ports and one read port.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (clears pointers/count)
//   wr_en[1:0]   - write strobes; port 0 is written ahead of port 1
//   wr_data0/1   - write data for each port
//   pop          - advance head (caller guarantees count>0)
//   head_data    - element at head (combinational read)
//   count        - number of stored elements
// The caller guarantees enough free space for the writes it requests.
module frq_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [5:0]
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              wr_en,
    input  T                        wr_data0,
    input  T                        wr_data1,
    input  logic                    pop,
    output T                        head_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    T mem [DEPTH];

    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW-1:0] wr_idx1;
    logic [AW:0]   n_writes;

    // Port 1 lands right behind port 0 only when port 0 actually writes,
    // so a lone slot-1 write still goes to the current tail.
    assign wr_idx1   = wr_en[0] ? tail_reg + AW'(1) : tail_reg;
    assign n_writes  = (AW+1)'(wr_en[0]) + (AW+1)'(wr_en[1]);
    assign tail_next = tail_reg + AW'(n_writes);
    assign head_next = pop ? head_reg + AW'(1) : head_reg;
    assign count_next = count_reg + n_writes - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[tail_reg] <= wr_data0;
        if (wr_en[1]) mem[wr_idx1]  <= wr_data1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign head_data = mem[head_reg];
    assign count     = count_reg;
endmodule

// File: rtl/free_release_queue.sv
// free_release_queue: buffers superseded physical tags from up to two retiring
// instructions per cycle and releases one per cycle to the free list.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - free_release_queue_if.slave:
//                commit_valid/has_dest/old_phys in, commit_ready out,
//                free_en/free_phys (registered release), occupancy, drop_err
// Build option: define FREE_DUP_CHECK_EN to track a pending mask and refuse
// duplicate tags (dropped tags set drop_err).
module free_release_queue
    import core_pkg::*;
#(
    parameter int PHYS_REGS = PREGS,
    parameter int DEPTH     = 16,
    parameter int ZERO_PREG = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    free_release_queue_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [TAG_W:0] PREGS_LIM = (TAG_W+1)'(PHYS_REGS);
    localparam phys_tag_t      ZERO_TAG  = phys_tag_t'(ZERO_PREG);

    logic [CW-1:0]           count;
    logic                    commit_ready;
    logic [COMMIT_WIDTH-1:0] qual;
    logic [COMMIT_WIDTH-1:0] dup;
    logic [COMMIT_WIDTH-1:0] accept;
    phys_tag_t               head_tag;
    logic                    pop;

    logic      free_en_reg;
    phys_tag_t free_phys_reg;
    logic      drop_err_reg, drop_err_next;

    assign commit_ready = (CW'(DEPTH) - count) >= CW'(2);
    assign pop          = (count != '0);

    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_slot
        // XZR's tag and tags beyond the register file are silently ignored.
        assign qual[gi] = bus.commit_valid[gi] & bus.commit_has_dest[gi]
                        & (bus.commit_old_phys[gi] != ZERO_TAG)
                        & ({1'b0, bus.commit_old_phys[gi]} < PREGS_LIM);
        assign accept[gi] = qual[gi] & commit_ready & ~dup[gi];
    end

`ifdef FREE_DUP_CHECK_EN
    logic [PHYS_REGS-1:0] pending_reg, pending_next;

    // Slot 1 also loses against a qualifying slot 0 carrying the same tag.
    always_comb begin
        dup    = '0;
        dup[0] = pending_reg[bus.commit_old_phys[0]];
        dup[1] = pending_reg[bus.commit_old_phys[1]]
               | (qual[0] & (bus.commit_old_phys[0] == bus.commit_old_phys[1]));
    end

    // An accepted tag is never pending, so it can never be the tag being
    // popped this cycle; clear-then-set order is therefore conflict-free.
    always_comb begin
        pending_next = pending_reg;
        if (pop) pending_next[head_tag] = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (accept[i]) pending_next[bus.commit_old_phys[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pending_reg <= '0;
        else       pending_reg <= pending_next;
    end

    assign drop_err_next = drop_err_reg
                         | ((|bus.commit_valid) & ~commit_ready)
                         | (|(qual & dup));
`else
    assign dup           = '0;
    assign drop_err_next = drop_err_reg | ((|bus.commit_valid) & ~commit_ready);
`endif

    frq_fifo #(
        .DEPTH (DEPTH),
        .T     (phys_tag_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (accept),
        .wr_data0  (bus.commit_old_phys[0]),
        .wr_data1  (bus.commit_old_phys[1]),
        .pop       (pop),
        .head_data (head_tag),
        .count     (count)
    );

    // Release register: the popped tag becomes visible the cycle after the pop.
    // free_phys keeps its last value while the queue is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_en_reg   <= 1'b0;
            free_phys_reg <= '0;
            drop_err_reg  <= 1'b0;
        end else begin
            free_en_reg  <= pop;
            if (pop) free_phys_reg <= head_tag;
            drop_err_reg <= drop_err_next;
        end
    end

    assign bus.commit_ready = commit_ready;
    assign bus.free_en      = free_en_reg;
    assign bus.free_phys    = free_phys_reg;
    assign bus.occupancy    = count;
    assign bus.drop_err     = drop_err_reg;
endmodule
